// File: rtl/user_clock_monitor_if.sv
// User-clock monitor bundle: the incoming user clock and the status it produces.
// The monitor takes the master side; status consumers (and the clock source) take the slave side.
interface user_clock_monitor_if;
  logic        CLK_USER;
  logic [15:0] PERIOD;
  logic [15:0] HIGH_TIME;
  logic        PERIOD_VLD;
  logic        LOCKED;
  logic        LOST;
  logic [7:0]  BAD_CNT;
  logic        RST_USER_OUT;

  modport master (
    input  CLK_USER,
    output PERIOD, HIGH_TIME, PERIOD_VLD, LOCKED, LOST, BAD_CNT, RST_USER_OUT
  );

  modport slave (
    output CLK_USER,
    input  PERIOD, HIGH_TIME, PERIOD_VLD, LOCKED, LOST, BAD_CNT, RST_USER_OUT
  );
endinterface

// File: rtl/user_clock_monitor.sv
// Receive-side user-clock checker: measures period/high time of CLK_USER in
// CLK_IN cycles, locks after a run of in-tolerance periods, flags clock loss
// and holds the user-logic reset until the clock has been stable long enough.
module user_clock_monitor #(
  parameter int NOM_PERIOD = 50,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 8,
  parameter int RST_HOLD   = 5,
  parameter int TIMEOUT    = 100
) (
  input  logic                 CLK_IN,
  input  logic                 RST,
  user_clock_monitor_if.master ucm
);

  localparam logic [15:0] P_LO   = 16'(NOM_PERIOD - TOL);
  localparam logic [15:0] P_HI   = 16'(NOM_PERIOD + TOL);
  localparam logic [15:0] T_OUT  = 16'(TIMEOUT);
  localparam logic [7:0]  LC_N   = 8'(LOCK_COUNT);
  localparam logic [7:0]  RH_N   = 8'(RST_HOLD);

  typedef enum logic [1:0] {IDLE, MEASURE, HOLD, RUN} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [15:0] cnt_q, period_q, high_q;
  logic        vld_q, lost_q, seen_q;
  logic        locked_q, rst_user_q;
  logic [7:0]  bad_q, bad_d, good_q, good_d, hold_q, hold_d;
  logic [7:0]  bad_inc;
  logic        rise, fall, period_evt, good, timeout;

  // Edge pulses come from the last two synchronizer stages; s1 only absorbs metastability.
  assign rise       = s2_q & ~s3_q;
  assign fall       = ~s2_q & s3_q;
  // The arming rise after reset or loss has no previous rise to measure against.
  assign period_evt = rise & seen_q;
  assign good       = (cnt_q >= P_LO) && (cnt_q <= P_HI);
  // A rise landing on the timeout count wins: it is judged as a (bad) period instead.
  assign timeout    = (state_q != IDLE) && (cnt_q == T_OUT) && !rise;
  assign bad_inc    = (bad_q == 8'hFF) ? bad_q : bad_q + 8'd1;

  // Synchronizer, interval counter and measurement registers.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= 16'd0;
      period_q <= 16'd0;
      high_q   <= 16'd0;
      vld_q    <= 1'b0;
      lost_q   <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      s1_q <= ucm.CLK_USER;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (rise) begin
        cnt_q <= 16'd1;
      end else if (cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (fall && seen_q) begin
        high_q <= cnt_q;
      end
      vld_q <= period_evt;
      if (period_evt) begin
        period_q <= cnt_q;
      end
      if (rise) begin
        seen_q <= 1'b1;
        lost_q <= 1'b0;
      end else if (timeout) begin
        seen_q <= 1'b0;
        lost_q <= 1'b1;
      end
    end
  end

  // Lock FSM state, counters and the status flags registered from next-state.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q    <= IDLE;
      good_q     <= 8'd0;
      hold_q     <= 8'd0;
      bad_q      <= 8'd0;
      locked_q   <= 1'b0;
      rst_user_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      hold_q     <= hold_d;
      bad_q      <= bad_d;
      locked_q   <= (state_d == HOLD) || (state_d == RUN);
      rst_user_q <= (state_d != RUN);
    end
  end

  // Next-state: count good periods to lock, count rising edges to release reset, drop on bad or lost clock.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    hold_d  = hold_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          good_d  = 8'd0;
        end
      end
      MEASURE: begin
        if (period_evt) begin
          if (good) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 == LC_N) begin
              state_d = HOLD;
              hold_d  = 8'd0;
            end
          end else begin
            good_d = 8'd0;
            bad_d  = bad_inc;
          end
        end
      end
      HOLD: begin
        if (period_evt) begin
          if (good) begin
            hold_d = hold_q + 8'd1;
            if (hold_q + 8'd1 == RH_N) begin
              state_d = RUN;
            end
          end else begin
            state_d = MEASURE;
            good_d  = 8'd0;
            bad_d   = bad_inc;
          end
        end
      end
      RUN: begin
        if (period_evt && !good) begin
          state_d = MEASURE;
          good_d  = 8'd0;
          bad_d   = bad_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
    end
  end

  assign ucm.PERIOD       = period_q;
  assign ucm.HIGH_TIME    = high_q;
  assign ucm.PERIOD_VLD   = vld_q;
  assign ucm.LOCKED       = locked_q;
  assign ucm.LOST         = lost_q;
  assign ucm.BAD_CNT      = bad_q;
  assign ucm.RST_USER_OUT = rst_user_q;

endmodule

// File: doc/user_clock_monitor.md
# user_clock_monitor

Receive-side checker for the 2 MHz user clock generated in the 100 MHz domain. It samples the slow clock with CLK_IN, measures its period and high time in CLK_IN cycles, and declares lock after a run of in-tolerance periods. It also detects clock loss and drives a downstream user reset that is held until the clock is proven stable. It sits at the consuming end of the user-clock path, for example at the far side of a board or cable hop, and feeds status registers and the user-logic reset tree.

## Interface
- NOM_PERIOD, 50: nominal user-clock period in CLK_IN cycles.
- TOL, 2: allowed |period − NOM_PERIOD|, inclusive.
- LOCK_COUNT, 8: consecutive good periods required for lock (1..255).
- RST_HOLD, 5: user-clock rising edges RST_USER_OUT stays high after lock (1..255).
- TIMEOUT, 100: CLK_IN cycles without a rising edge that count as clock loss (must be > NOM_PERIOD+TOL, < 65535).
- CLK_IN  in  1  100 MHz system clock; all logic in this domain.
- RST  in  1  reset, synchronous, active-high.
- CLK_USER  in  1  incoming 2 MHz user clock, asynchronous to CLK_IN.
- PERIOD  out  16  last measured period (CLK_IN cycles).
- HIGH_TIME  out  16  last measured high time (CLK_IN cycles).
- PERIOD_VLD  out  1  one-cycle strobe when PERIOD updates.
- LOCKED  out  1  high in HOLD and RUN states.
- LOST  out  1  set on timeout, cleared on next rising edge.
- BAD_CNT  out  8  saturating count of out-of-tolerance periods.
- RST_USER_OUT  out  1  reset for user logic; high unless in RUN.

## Operation
- Synchronizer: CLK_USER passes through s1, s2, s3 flops. rise = s2 & ~s3; fall = ~s2 & s3.
- Counter cnt (16 bit):
  - On rise, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 16'hFFFF.
  - The value of cnt at a rise or fall pulse is the interval since the previous rise.
- On fall with seen=1: HIGH_TIME <= cnt.
- On rise with seen=1:
  - PERIOD <= cnt and PERIOD_VLD <= 1.
  - good = (cnt ≥ NOM_PERIOD−TOL) && (cnt ≤ NOM_PERIOD+TOL).
- On any rise: seen <= 1 and LOST <= 0. The first rise after reset or timeout only arms measurement; it produces no PERIOD_VLD.
- FSM states and transitions:
  - IDLE: on rise, go to MEASURE with good_cnt <= 0.
  - MEASURE:
    - Good period: good_cnt+1. When good_cnt+1 == LOCK_COUNT, go to HOLD with hold_cnt <= 0.
    - Bad period: good_cnt <= 0 and BAD_CNT+1.
  - HOLD: each good period increments hold_cnt. When hold_cnt+1 == RST_HOLD, go to RUN.
  - RUN: stays in RUN while periods are good.
  - Bad period in HOLD or RUN: go to MEASURE, good_cnt <= 0, BAD_CNT+1.
  - Timeout in any state except IDLE: when cnt == TIMEOUT and no rise this cycle, go to IDLE, seen <= 0, LOST <= 1.
- Simultaneous events:
  - Rise and cnt == TIMEOUT in the same cycle: the rise wins. The period is judged normally; LOST is not set.
  - BAD_CNT holds at 255.
- LOCKED = state ∈ {HOLD, RUN}. RST_USER_OUT = (state ≠ RUN). Both are registered from next-state.

## Timing
- Reset values:
  - State IDLE; cnt, PERIOD, HIGH_TIME, BAD_CNT = 0.
  - PERIOD_VLD, LOCKED, LOST = 0; RST_USER_OUT = 1; seen = 0; s1..s3 = 0.
- RST applies on the next CLK_IN edge from any state, including mid-lock. RST_USER_OUT is 1 the cycle after RST is sampled.
- Edge latency: a CLK_USER edge is seen as a rise/fall pulse 3 CLK_IN cycles after it. Ambiguity is ±1 cycle, so measured periods jitter by ±1.
- Register updates at the rise pulse:
  - PERIOD, PERIOD_VLD, BAD_CNT, LOCKED and RST_USER_OUT update on the CLK_IN edge ending the rise-pulse cycle.
  - PERIOD_VLD is high for exactly 1 cycle.
- LOST rises 1 cycle after the cycle in which cnt == TIMEOUT.
- Cold start at NOM_PERIOD:
  - LOCKED rises at rise #(LOCK_COUNT+1).
  - RST_USER_OUT falls at rise #(LOCK_COUNT+RST_HOLD+1).

## Test plan
- Nominal clock (50-cycle period, 25 high), defaults:
  - PERIOD=50 and HIGH_TIME=25 (±1) from rise #2.
  - LOCKED=1 after rise #9.
  - RST_USER_OUT=0 after rise #14.
  - BAD_CNT=0 and LOST=0 throughout.
- While in RUN, inject one 55-cycle period:
  - Next cycle LOCKED=0, RST_USER_OUT=1, BAD_CNT=1.
  - Relock: LOCKED=1 after 8 more good periods; RST_USER_OUT=0 after 13.
- Tolerance edges: periods 48 and 52 count as good; 47 and 53 each increment BAD_CNT and clear good_cnt.
- Stop CLK_USER (held low) while in RUN:
  - LOST=1 and RST_USER_OUT=1 exactly 101 cycles after the last rise pulse.
  - On restart, the first rise clears LOST with no PERIOD_VLD; lock follows after 8 good periods.
- Assert RST for 1 cycle in RUN mid-period: all outputs return to reset values next cycle, and the lock sequence restarts from IDLE.
- Force 300 bad periods: BAD_CNT saturates at 255. Rise coincident with cnt==TIMEOUT gives PERIOD=100, bad period, LOST stays 0.
